// File: rtl/sm4_pkg.sv
// Shared SM4 sequencer definitions: FSM states, FK constant, round count and
// the arithmetic CK byte generator.
package sm4_pkg;

  localparam int unsigned SM4_ROUNDS = 32;
  localparam logic [127:0] SM4_FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREKEY,
    ST_ROUND,
    ST_FINAL
  } state_e;

  // Byte j of CK_i is (4i+j)*7 mod 256; {i, j} is exactly 4i+j in 8 bits.
  function automatic logic [7:0] ck_byte(input logic [5:0] i, input logic [1:0] j);
    logic [7:0] idx;
    idx = {i, j};
    return 8'(idx * 8'd7);
  endfunction

endpackage

// File: rtl/sm4_ck_gen.sv
// Combinational CK digit generator: selects the forward or inverse CK word for
// the current round and slices out the digit for the current beat, MSB first.
module sm4_ck_gen
  import sm4_pkg::*;
#(
  parameter int unsigned DW      = 1,
  parameter int unsigned NROUNDS = SM4_ROUNDS,
  parameter int unsigned BW      = 7
) (
  input  logic [5:0]    round_idx_i,
  input  logic [BW-1:0] beat_i,
  input  logic          key_dir_i,
  input  logic          en_i,
  output logic [DW-1:0] ck_digit_o
);

  logic [5:0]  ck_i;
  logic [31:0] ck_word;
  logic [31:0] ck_sh;
  logic [4:0]  shamt;

  always_comb begin
    ck_i       = key_dir_i ? (6'(NROUNDS - 1) - round_idx_i) : round_idx_i;
    ck_word    = {ck_byte(ck_i, 2'd0), ck_byte(ck_i, 2'd1),
                  ck_byte(ck_i, 2'd2), ck_byte(ck_i, 2'd3)};
    shamt      = 5'(DW * beat_i);
    ck_sh      = ck_word << shamt;
    ck_digit_o = en_i ? ck_sh[31 -: DW] : '0;
  end

endmodule

// File: rtl/sm4_serial_ctrl.sv
// Digit-serial SM4 control sequencer: LOAD, optional forward key pre-expansion,
// NROUNDS round iterations and FINAL unload, with FK/CK digits generated in place.
module sm4_serial_ctrl
  import sm4_pkg::*;
#(
  parameter int unsigned DW      = 1,
  parameter int unsigned NROUNDS = SM4_ROUNDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          load_en,
  output logic          key_en,
  output logic          key_dir,
  output logic          data_en,
  output logic          out_en,
  output logic [DW-1:0] fk_digit,
  output logic [DW-1:0] ck_digit,
  output logic          word_first,
  output logic          word_last,
  output logic          sbox_ld,
  output logic [5:0]    round_idx
);

  localparam int unsigned WB = 32 / DW;
  localparam int unsigned BB = 128 / DW;
  localparam int unsigned BW = $clog2(BB);

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [5:0]    round_q, round_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;

  logic          in_sched;
  logic          word_wrap;
  logic          blk_wrap;
  logic          round_wrap;
  logic [127:0]  fk_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign in_sched   = (state_q == ST_PREKEY) || (state_q == ST_ROUND);
  assign word_wrap  = (beat_q == BW'(WB - 1));
  assign blk_wrap   = (beat_q == BW'(BB - 1));
  assign round_wrap = (round_q == 6'(NROUNDS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    round_d = round_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      round_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            mode_d  = mode;
            beat_d  = '0;
            round_d = '0;
          end
        end
        ST_LOAD: begin
          if (blk_wrap) begin
            beat_d  = '0;
            state_d = mode_q ? ST_PREKEY : ST_ROUND;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        ST_PREKEY, ST_ROUND: begin
          if (word_wrap) begin
            beat_d = '0;
            if (round_wrap) begin
              round_d = '0;
              state_d = (state_q == ST_PREKEY) ? ST_ROUND : ST_FINAL;
            end else begin
              round_d = round_q + 6'(1);
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        ST_FINAL: begin
          if (blk_wrap) begin
            beat_d  = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Enables and digits decode the registered state and beat directly.
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign load_en    = (state_q == ST_LOAD);
  assign key_en     = in_sched;
  assign key_dir    = (state_q == ST_ROUND) && mode_q;
  assign data_en    = (state_q == ST_ROUND);
  assign out_en     = (state_q == ST_FINAL);
  assign word_first = in_sched && (beat_q == '0);
  assign word_last  = in_sched && word_wrap;
  assign sbox_ld    = in_sched && (3'(DW * beat_q) == 3'(8 - DW));
  assign round_idx  = round_q;

  assign fk_sh    = SM4_FK << 7'(DW * beat_q);
  assign fk_digit = load_en ? fk_sh[127 -: DW] : '0;

  sm4_ck_gen #(
    .DW      (DW),
    .NROUNDS (NROUNDS),
    .BW      (BW)
  ) u_ck_gen (
    .round_idx_i (round_q),
    .beat_i      (beat_q),
    .key_dir_i   (key_dir),
    .en_i        (in_sched),
    .ck_digit_o  (ck_digit)
  );

endmodule
